uart_rx_fifo: RTL and testbench

//  UART receiver with a byte FIFO. Drives the CPU's cpu_uart_rxd input path.

---
 rtl/uart_rx_fifo.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a show-ahead byte FIFO.
// The serial line is synchronised, framed by a small FSM with a bit timer,
// and each good byte is pushed into the FIFO for the MMIO load path to pop.
//
// Read handshake: empty==0 means rd_data holds a valid head byte. The reader
// asserts rd_en for one cycle to consume it; the pop happens on that clock
// edge. rd_en while empty==1 is ignored. The receiver never stalls: a byte
// that arrives while the FIFO is full, with no pop on the same edge, is dropped
// and overrun is set.
module uart_rx_fifo #(
    parameter int CLK_PER_BIT        = 868,
    parameter int FIFO_ADDR_BITWIDTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic       overrun,
    output logic       frame_error,
    input  logic       clear_errors
);

    localparam int TW    = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int AW    = FIFO_ADDR_BITWIDTH;
    localparam int DEPTH = 1 << AW;

    localparam logic [TW-1:0] BIT_LAST   = TW'(CLK_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST  = TW'(CLK_PER_BIT / 2 - 1);
    localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

    // Synchroniser
    logic rx_meta_q, rx_meta_d;
    logic rx_s_q, rx_s_d;

    // Receiver
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          push;
    logic          frame_err_evt;

    // FIFO
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          pop_ok;
    logic          push_ok;
    logic          overrun_evt;

    // Sticky error flags
    logic overrun_q, overrun_d;
    logic frame_error_q, frame_error_d;

    // Two-stage synchroniser for the asynchronous serial input.
    always_comb begin
        rx_meta_d = uart_rxd;
        rx_s_d    = rx_meta_q;
    end

    // Frame FSM: find the start edge, sample mid-bit, check the stop bit.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        push          = 1'b0;
        frame_err_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    timer_d = '0;
                end
            end
            ST_START: begin
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    if (!rx_s_q) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end else begin
                        // Line went back high before mid start bit: a glitch.
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (timer_q == BIT_LAST) begin
                    timer_d            = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_evt = 1'b1;
                        state_d       = ST_WAIT_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                // Hold off until the line returns high (break or noise).
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping: a pop frees a slot on the same edge as a push.
    always_comb begin
        pop_ok      = rd_en && (count_q != '0);
        push_ok     = push && ((count_q != COUNT_FULL) || pop_ok);
        overrun_evt = push && (count_q == COUNT_FULL) && !pop_ok;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Sticky flags: a new event on the clearing edge keeps the flag set.
    always_comb begin
        overrun_d     = overrun_q;
        frame_error_d = frame_error_q;
        if (clear_errors) begin
            overrun_d     = 1'b0;
            frame_error_d = 1'b0;
        end
        if (overrun_evt) begin
            overrun_d = 1'b1;
        end
        if (frame_err_evt) begin
            frame_error_d = 1'b1;
        end
    end

    // State registers; reset abandons any partial frame and empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            mem_q         <= '{default: '0};
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            rx_meta_q     <= rx_meta_d;
            rx_s_q        <= rx_s_d;
            state_q       <= state_d;
            timer_q       <= timer_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overrun_q     <= overrun_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign empty       = (count_q == '0);
    assign full        = (count_q == COUNT_FULL);
    assign rd_data     = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign overrun     = overrun_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo with 16 clocks per bit and a 4-entry FIFO.
// A queue-based reference model tracks the FIFO contents and sticky flags
// per frame; frame timing is derived from the bit period, not from the RTL.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic       clk          = 1'b0;
    logic       reset        = 1'b1;
    logic       uart_rxd     = 1'b1;
    logic       rd_en        = 1'b0;
    logic       clear_errors = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic       overrun;
    logic       frame_error;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: bytes held, and the two sticky flags.
    logic [7:0] model_q[$];
    logic       m_overrun = 1'b0;
    logic       m_ferr    = 1'b0;

    uart_rx_fifo #(
        .CLK_PER_BIT        (CPB),
        .FIFO_ADDR_BITWIDTH (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rxd     (uart_rxd),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .overrun      (overrun),
        .frame_error  (frame_error),
        .clear_errors (clear_errors)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check($sformatf("%s.empty", tag), 32'(empty), 32'(model_q.size() == 0));
        check($sformatf("%s.full", tag), 32'(full), 32'(model_q.size() == DEPTH));
        check($sformatf("%s.overrun", tag), 32'(overrun), 32'(m_overrun));
        check($sformatf("%s.frame_error", tag), 32'(frame_error), 32'(m_ferr));
        if (model_q.size() > 0) begin
            check($sformatf("%s.rd_data", tag), 32'(rd_data), 32'(model_q[0]));
        end
    endtask

    // Sends one 8N1 frame starting at a falling clock edge. The receiver's
    // stop sample lands on the rising edge right after the 154th falling edge;
    // rd_en / clear_errors can be asserted for exactly that edge.
    task automatic send_frame(input string tag, input logic [7:0] b, input logic stop_val,
                              input logic pop_at_stop, input logic clr_at_stop);
        logic [7:0] tmp;
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = stop_val;
        repeat (10) @(negedge clk);
        check_all($sformatf("%s.pre_stop", tag));
        rd_en        = pop_at_stop;
        clear_errors = clr_at_stop;
        @(negedge clk);
        rd_en        = 1'b0;
        clear_errors = 1'b0;
        if (clr_at_stop) begin
            m_overrun = 1'b0;
            m_ferr    = 1'b0;
        end
        if (pop_at_stop && model_q.size() > 0) begin
            tmp = model_q.pop_front();
        end
        if (stop_val) begin
            if (model_q.size() == DEPTH) m_overrun = 1'b1;
            else model_q.push_back(b);
        end else begin
            m_ferr = 1'b1;
        end
        check_all($sformatf("%s.stop", tag));
        repeat (5) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_byte(input string tag);
        logic [7:0] tmp;
        if (model_q.size() > 0) begin
            check($sformatf("%s.head", tag), 32'(rd_data), 32'(model_q[0]));
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (model_q.size() > 0) begin
            tmp = model_q.pop_front();
        end
        check_all($sformatf("%s.after_pop", tag));
    endtask

    task automatic clear_flags(input string tag);
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
        m_overrun = 1'b0;
        m_ferr    = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rstop;
        logic       rpop;
        logic       rclr;
        int         npop;

        // Reset state.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset.rd_data", 32'(rd_data), 32'h0);
        check_all("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_all("post_reset");

        // 1: single byte, latency to stop sample, pop, pop while empty.
        send_frame("t1", 8'hA5, 1'b1, 1'b0, 1'b0);
        check("t1.value", 32'(rd_data), 32'hA5);
        pop_byte("t1.pop");
        pop_byte("t1.pop_empty");

        // 2: fill past depth, overrun on the fifth byte, drain in order.
        for (int i = 1; i <= 5; i++) begin
            send_frame($sformatf("t2.b%0d", i), 8'(i), 1'b1, 1'b0, 1'b0);
        end
        check("t2.full", 32'(full), 32'h1);
        check("t2.overrun", 32'(overrun), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("t2.order%0d", i), 32'(rd_data), 32'(i));
            pop_byte($sformatf("t2.pop%0d", i));
        end
        clear_flags("t2.clear");

        // 3: short low glitch is rejected.
        uart_rxd = 1'b0;
        repeat (4) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (40) @(negedge clk);
        check_all("t3.glitch");

        // 4: stop bit held low -> frame error; clear; next frame clean.
        send_frame("t4.bad", 8'h3C, 1'b0, 1'b0, 1'b0);
        check("t4.ferr", 32'(frame_error), 32'h1);
        clear_flags("t4.clear");
        send_frame("t4.good", 8'h3C, 1'b1, 1'b0, 1'b0);
        pop_byte("t4.pop");

        // 5: full FIFO, pop on the stop-sample edge: no overrun, 0x77 last.
        for (int i = 0; i < 4; i++) begin
            send_frame($sformatf("t5.fill%0d", i), 8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
        end
        send_frame("t5.same", 8'h77, 1'b1, 1'b1, 1'b0);
        check("t5.no_overrun", 32'(overrun), 32'h0);
        check("t5.full", 32'(full), 32'h1);
        for (int i = 0; i < 3; i++) begin
            pop_byte($sformatf("t5.pop%0d", i));
        end
        check("t5.last", 32'(rd_data), 32'h77);
        pop_byte("t5.pop3");

        // 6: reset mid-frame with bytes queued and a flag set.
        send_frame("t6.q0", 8'h11, 1'b1, 1'b0, 1'b0);
        send_frame("t6.q1", 8'h22, 1'b1, 1'b0, 1'b0);
        send_frame("t6.bad", 8'h33, 1'b0, 1'b0, 1'b0);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (40) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_q.delete();
        m_overrun = 1'b0;
        m_ferr    = 1'b0;
        check("t6.rd_data", 32'(rd_data), 32'h0);
        check_all("t6.reset");
        reset = 1'b0;
        repeat (CPB * 8) @(negedge clk);
        check_all("t6.idle");
        send_frame("t6.next", 8'h5A, 1'b1, 1'b0, 1'b0);
        pop_byte("t6.pop");

        // Randomised frames, stop bits, same-edge pops and clears.
        for (int n = 0; n < 14; n++) begin
            rb    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 7) != 0);
            rpop  = ($urandom_range(0, 3) == 0);
            rclr  = ($urandom_range(0, 5) == 0);
            send_frame($sformatf("rnd%0d", n), rb, rstop, rpop, rclr);
            npop = $urandom_range(0, 2);
            for (int k = 0; k < npop; k++) begin
                pop_byte($sformatf("rnd%0d.pop%0d", n, k));
            end
            if ($urandom_range(0, 4) == 0) begin
                clear_flags($sformatf("rnd%0d.clear", n));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
